// File: rtl/tilemap_arbiter_pkg.sv
// Shared types and default sizes for the tile-map RAM arbiter.
package tilemap_pkg;

  typedef enum logic [1:0] {REQ_VGA, REQ_COL, REQ_CPU} req_e;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 1200;

endpackage

// File: rtl/tilemap_arbiter_rr_arb2.sv
// Two-way round-robin picker between collision and CPU; pointer passes the winner on each grant.
module rr_arb2
  import tilemap_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_col,
  input  logic req_cpu,
  output logic gnt_col,
  output logic gnt_cpu
);

  req_e ptr;

  always_comb begin
    gnt_col = 1'b0;
    gnt_cpu = 1'b0;
    if (req_col && req_cpu) begin
      if (ptr == REQ_COL) gnt_col = 1'b1;
      else                gnt_cpu = 1'b1;
    end else begin
      gnt_col = req_col;
      gnt_cpu = req_cpu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= REQ_COL;
    else if (gnt_col) ptr <= REQ_CPU;
    else if (gnt_cpu) ptr <= REQ_COL;
  end

endmodule

// File: rtl/tilemap_arbiter.sv
// Tile-map RAM arbiter: VGA priority with starvation guard, col/CPU round-robin, hardware clear.
// Build option TILEMAP_ARB_VBLANK_LOCK_EN: CPU writes only win arbitration while vblank is high.
module tilemap_arbiter
  import tilemap_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CLEAR_VAL  = 0,
  parameter int STARVE_MAX = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              col_req,
  input  logic [ADDR_W-1:0] col_addr,
  output logic              col_gnt,
  output logic              col_rvalid,
  output logic [DATA_W-1:0] col_rdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  input  logic              init_clear,
  input  logic              vblank,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] CLR_WORD   = DATA_W'(CLEAR_VAL);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_nxt;

  logic idle;
  logic cpu_req, cpu_elig, low_pend, vga_win;
  logic rr_col_req, rr_cpu_req, rr_col_gnt, rr_cpu_gnt;
  logic vga_vld_p1, col_vld_p1, cpu_vld_p1;
  req_e owner;
  logic owner_vld;

  assign idle    = (state == ST_IDLE);
  assign cpu_req = cpu_read | cpu_write;

  // A simultaneous read+write is a write, so the write gate decides eligibility.
`ifdef TILEMAP_ARB_VBLANK_LOCK_EN
  assign cpu_elig = cpu_write ? vblank : cpu_read;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign cpu_elig      = cpu_req;
`endif

  assign low_pend = col_req | cpu_elig;
  assign vga_win  = idle & vga_req & (~low_pend | (starve_cnt < STARVE_LIM));

  assign rr_col_req = idle & ~vga_win & col_req;
  assign rr_cpu_req = idle & ~vga_win & cpu_elig;

  rr_arb2 u_rr (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .req_col (rr_col_req),
    .req_cpu (rr_cpu_req),
    .gnt_col (rr_col_gnt),
    .gnt_cpu (rr_cpu_gnt)
  );

  assign vga_gnt         = vga_win;
  assign col_gnt         = rr_col_gnt;
  assign cpu_waitrequest = ~idle | (cpu_req & ~rr_cpu_gnt);

  always_comb begin
    owner     = REQ_VGA;
    owner_vld = 1'b1;
    if (vga_win)         owner = REQ_VGA;
    else if (rr_col_gnt) owner = REQ_COL;
    else if (rr_cpu_gnt) owner = REQ_CPU;
    else                 owner_vld = 1'b0;
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    busy        = 1'b0;
    ram_addr    = '0;
    ram_we      = 1'b0;
    ram_wdata   = '0;
    case (state)
      ST_IDLE: begin
        if (init_clear) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
        if (owner_vld) begin
          case (owner)
            REQ_VGA: ram_addr = vga_addr;
            REQ_COL: ram_addr = col_addr;
            REQ_CPU: begin
              ram_addr  = cpu_address;
              ram_we    = cpu_write;
              ram_wdata = cpu_write ? cpu_writedata : '0;
            end
            default: ram_addr = '0;
          endcase
        end
      end
      ST_CLEAR: begin
        busy      = 1'b1;
        ram_addr  = clr_cnt;
        ram_we    = 1'b1;
        ram_wdata = CLR_WORD;
        if (clr_cnt == CLR_LAST) begin
          state_nxt   = ST_IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Guard counts VGA wins only while someone else is actually waiting.
  always_comb begin
    starve_nxt = starve_cnt;
    if (rr_col_gnt || rr_cpu_gnt || !low_pend) starve_nxt = '0;
    else if (vga_win && (starve_cnt < STARVE_LIM)) starve_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) starve_cnt <= '0;
    else          starve_cnt <= starve_nxt;
  end

  // ---- stage p1: return tags; RAM data arrives one cycle after the grant
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vga_vld_p1 <= 1'b0;
      col_vld_p1 <= 1'b0;
      cpu_vld_p1 <= 1'b0;
    end else begin
      vga_vld_p1 <= vga_win;
      col_vld_p1 <= rr_col_gnt;
      cpu_vld_p1 <= rr_cpu_gnt & cpu_read & ~cpu_write;
    end
  end

  assign vga_rvalid        = vga_vld_p1;
  assign col_rvalid        = col_vld_p1;
  assign cpu_readdatavalid = cpu_vld_p1;
  assign vga_rdata         = vga_vld_p1 ? ram_rdata : '0;
  assign col_rdata         = col_vld_p1 ? ram_rdata : '0;
  assign cpu_readdata      = cpu_vld_p1 ? ram_rdata : '0;

endmodule

// File: doc/tilemap_arbiter.md
# tilemap_arbiter

Shares the single-port level tile-map RAM between three requesters: the VGA tile fetcher, the player collision checker, and the Nios II CPU over Avalon-MM. VGA has fixed top priority with a starvation guard. Collision and CPU rotate round-robin. The block also runs a hardware map-clear sequence on the level-initialize pulse, so software does not have to write every tile.

## Interface
- ADDR_W, 11: tile-map address width (40x30 = 1200 tiles used).
- DEPTH, 1200: number of tiles cleared by the clear sequence.
- DATA_W, 8: tile word width.
- CLEAR_VAL, 0: value written to every tile during clear.
- STARVE_MAX, 8: maximum consecutive VGA grants while a lower requester waits.

Ports:
- Clk  in  1  system clock (MAX10 50 MHz domain).
- Reset_n  in  1  asynchronous, active-low reset.
- vga_req, vga_addr  in  1, ADDR_W  VGA read request.
- vga_gnt  out  1  VGA request accepted this cycle.
- vga_rvalid, vga_rdata  out  1, DATA_W  VGA read return.
- col_req, col_addr  in  1, ADDR_W  collision read request.
- col_gnt  out  1  collision request accepted this cycle.
- col_rvalid, col_rdata  out  1, DATA_W  collision read return.
- cpu_read, cpu_write  in  1 each  Avalon-MM commands.
- cpu_address  in  ADDR_W  Avalon-MM address.
- cpu_writedata  in  DATA_W  Avalon-MM write data.
- cpu_waitrequest  out  1  Avalon-MM stall.
- cpu_readdata, cpu_readdatavalid  out  DATA_W, 1  Avalon-MM read return.
- init_clear  in  1  level-initialize pulse; starts the clear sequence.
- vblank  in  1  vertical blanking from the VGA controller.
- busy  out  1  high while the clear sequence is running.
- ram_addr, ram_we, ram_wdata  out  ADDR_W, 1, DATA_W  RAM port.
- ram_rdata  in  DATA_W  RAM read data (synchronous, 1-cycle latency).

## Operation
- FSM states:
  - IDLE: arbitrate requesters.
  - CLEAR: write CLEAR_VAL to addresses 0..DEPTH-1, one per cycle; all gnt = 0; cpu_waitrequest = 1.
  - Transition IDLE->CLEAR when init_clear=1 is sampled. CLEAR->IDLE on the cycle after the write to DEPTH-1.
- init_clear during CLEAR is ignored; the sequence does not restart.
- Arbitration in IDLE gives at most one grant per cycle:
  1. VGA, if vga_req and starve_cnt < STARVE_MAX.
  2. Otherwise the round-robin winner of col_req and CPU (cpu_read|cpu_write). Pointer starts at COL and moves past the winner after each grant.
  3. If only VGA requests, VGA is granted regardless of starve_cnt.
- starve_cnt:
  - Increments on a VGA grant while col or CPU is pending.
  - Clears on any col or CPU grant, or when neither is pending.
  - Saturates at STARVE_MAX.
- Grant signals:
  - gnt and the ram_* mux are combinational from current requests and registered state.
  - cpu_waitrequest = (cpu_read|cpu_write) & ~cpu_granted.
- cpu_read and cpu_write both high: treated as a write; no readdatavalid.
- Writes come only from CPU and CLEAR. VGA and collision are read-only.

## Timing
- Read latency is exactly 1 cycle: grant in cycle N, then rvalid/readdatavalid with data in N+1 for one cycle.
- The return tag is registered, so a grant in the last IDLE cycle still returns its data during the first CLEAR cycle.
- CPU write completes in its grant cycle, with waitrequest low that cycle.
- Clear takes DEPTH cycles. busy is high from the cycle after init_clear is sampled through the final write.
- Reset values:
  - All gnt, rvalid, readdatavalid, ram_we and busy = 0.
  - rdata buses = 0.
  - FSM = IDLE, rr pointer = COL, starve_cnt = 0, clear counter = 0.
- Reset asserted mid-clear aborts the sequence. The map stays partially cleared; there is no resume.

## Configuration
- TILEMAP_ARB_VBLANK_LOCK_EN:
  - Defined: CPU writes are eligible for grant only while vblank=1, which gives tear-free map edits. Outside vblank, cpu_waitrequest stays high for writes. CPU reads are unaffected.
  - Undefined: vblank is ignored and CPU writes arbitrate normally.

## Structure
- Package tilemap_pkg holds:
  - The requester enum (REQ_VGA, REQ_COL, REQ_CPU).
  - The FSM state enum (ST_IDLE, ST_CLEAR).
  - Default localparams for ADDR_W, DATA_W and DEPTH.
- One sub-module, rr_arb2: the two-way round-robin picker with its pointer register.
- The FSM, starvation counter and return-tag pipeline stay in the top.

## Test plan
- VGA reads addr 5 holding 8'h3C -> vga_gnt in cycle N; vga_rvalid=1 with vga_rdata=8'h3C in N+1.
- col_req and cpu_read held continuously, VGA idle -> grants alternate COL, CPU, COL, CPU, starting with COL after reset.
- vga_req held while col_req is pending, STARVE_MAX=8 -> exactly 8 VGA grants, then 1 col grant, then VGA resumes.
- init_clear pulse with DEPTH=1200 -> busy high for 1200 cycles. CPU reads of addresses 0, 599 and 1199 afterwards return 8'h00. cpu_waitrequest stays high throughout the clear.
- Reset_n asserted at clear address 300 -> all outputs go to their reset values immediately; address 900 keeps its prior contents.
- With TILEMAP_ARB_VBLANK_LOCK_EN, cpu_write with vblank=0 -> waitrequest held. vblank rises -> write granted that cycle.
